// File: rtl/cpu_pkg.sv
// Shared CPU package: arbiter state encoding and default arbiter limits.
package cpu_pkg;

    // Data-memory port arbiter states.
    typedef enum logic [0:0] {
        ARB_IDLE      = 1'b0,
        ARB_HOST_RESP = 1'b1
    } arb_state_t;

    // Default cap on how many cycles CPU traffic may defer a host request.
    localparam int unsigned DMEM_ARB_MAX_WAIT_DEF = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and synchronous active-low reset.
// Clear takes priority over increment; the count sticks at MAX.
module sat_counter #(
    parameter int unsigned          WIDTH = 4,
    parameter logic [WIDTH-1:0]     MAX   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;

    // Next count: clear wins, otherwise increment until MAX is reached.
    always_comb begin
        count_next_s = count_r;
        if (clr) begin
            count_next_s = {WIDTH{1'b0}};
        end else if (inc && (count_r != MAX)) begin
            count_next_s = count_r + WIDTH'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares the single SRAM port between the CPU MEM
// stage (priority) and the external host port. A host request deferred for
// HOST_MAX_WAIT cycles is forced through and the CPU is stalled for that cycle.
// Optional feature macro: DMEM_ARB_STATS_EN builds host-grant / CPU-stall
// statistics counters; without it the stat ports are tied to zero.
module dmem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned HOST_MAX_WAIT = DMEM_ARB_MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_wen,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       stat_host_grants,
    output logic [15:0]       stat_cpu_stalls
);

    arb_state_t state_r;
    arb_state_t state_next_s;

    logic       cpu_act_s;
    logic       starve_s;
    logic       host_gnt_s;
    logic       cpu_stall_s;
    logic       host_rd_r;
    logic [3:0] wait_cnt_s;
    logic       wait_inc_s;
    logic       wait_clr_s;

    assign cpu_act_s   = cpu_req & enable;
    assign starve_s    = (wait_cnt_s == 4'(HOST_MAX_WAIT));
    assign host_gnt_s  = (state_r == ARB_IDLE) & host_req & (~cpu_act_s | starve_s);
    assign cpu_stall_s = arst_n & host_gnt_s & cpu_act_s;

    // Host wait counter: counts idle cycles a pending host request is deferred.
    assign wait_clr_s = host_gnt_s | ~host_req;
    assign wait_inc_s = (state_r == ARB_IDLE) & host_req & ~host_gnt_s;

    sat_counter #(
        .WIDTH (4),
        .MAX   (4'(HOST_MAX_WAIT))
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (arst_n),
        .inc   (wait_inc_s),
        .clr   (wait_clr_s),
        .count (wait_cnt_s)
    );

    // FSM state register; a transaction in flight at reset is dropped.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: a grant moves to the response cycle, which always returns.
    always_comb begin
        state_next_s = ARB_IDLE;
        case (state_r)
            ARB_IDLE: begin
                if (host_gnt_s) begin
                    state_next_s = ARB_HOST_RESP;
                end else begin
                    state_next_s = ARB_IDLE;
                end
            end
            ARB_HOST_RESP: begin
                state_next_s = ARB_IDLE;
            end
            default: begin
                state_next_s = ARB_IDLE;
            end
        endcase
    end

    // Remember at grant time whether the host access was a read.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            host_rd_r <= 1'b0;
        end else if (host_gnt_s) begin
            host_rd_r <= ~host_wen;
        end else begin
            host_rd_r <= host_rd_r;
        end
    end

    // FSM outputs: port routing, stall, host handshake; all forced low in reset.
    always_comb begin
        mem_addr   = {ADDR_W{1'b0}};
        mem_wdata  = {DATA_W{1'b0}};
        mem_wen    = 1'b0;
        mem_ren    = 1'b0;
        cpu_stall  = 1'b0;
        host_ack   = 1'b0;
        host_rdata = {DATA_W{1'b0}};
        cpu_rdata  = {DATA_W{1'b0}};
        if (!arst_n) begin
            mem_addr   = {ADDR_W{1'b0}};
            mem_wdata  = {DATA_W{1'b0}};
            mem_wen    = 1'b0;
            mem_ren    = 1'b0;
            cpu_stall  = 1'b0;
            host_ack   = 1'b0;
            host_rdata = {DATA_W{1'b0}};
            cpu_rdata  = {DATA_W{1'b0}};
        end else begin
            if (host_gnt_s) begin
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
                mem_wen   = host_wen;
                mem_ren   = ~host_wen;
            end else if (cpu_act_s) begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_wen   = cpu_wen;
                mem_ren   = ~cpu_wen;
            end else begin
                mem_addr  = {ADDR_W{1'b0}};
                mem_wdata = {DATA_W{1'b0}};
                mem_wen   = 1'b0;
                mem_ren   = 1'b0;
            end
            cpu_stall = cpu_stall_s;
            cpu_rdata = mem_rdata;
            case (state_r)
                ARB_HOST_RESP: begin
                    host_ack = 1'b1;
                    if (host_rd_r) begin
                        host_rdata = mem_rdata;
                    end else begin
                        host_rdata = {DATA_W{1'b0}};
                    end
                end
                default: begin
                    host_ack   = 1'b0;
                    host_rdata = {DATA_W{1'b0}};
                end
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] host_grants_s;
    logic [15:0] cpu_stalls_s;
    logic        grant_inc_s;

    assign grant_inc_s = arst_n & host_gnt_s;

    sat_counter #(
        .WIDTH (16),
        .MAX   (16'hFFFF)
    ) u_stat_host_grants (
        .clk   (clk),
        .rst_n (arst_n),
        .inc   (grant_inc_s),
        .clr   (1'b0),
        .count (host_grants_s)
    );

    sat_counter #(
        .WIDTH (16),
        .MAX   (16'hFFFF)
    ) u_stat_cpu_stalls (
        .clk   (clk),
        .rst_n (arst_n),
        .inc   (cpu_stall_s),
        .clr   (1'b0),
        .count (cpu_stalls_s)
    );

    assign stat_host_grants = arst_n ? host_grants_s : 16'h0000;
    assign stat_cpu_stalls  = arst_n ? cpu_stalls_s  : 16'h0000;
`else
    assign stat_host_grants = 16'h0000;
    assign stat_cpu_stalls  = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a cycle table plus hand sequences for
// reset during a host response and the forced (starved) host grant.
module tb_dmem_port_arbiter;

    logic        clk;
    logic        arst_n;
    logic        enable;
    logic        cpu_req;
    logic        cpu_wen;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        host_req;
    logic        host_wen;
    logic [9:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_ack;
    logic [31:0] host_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_rdata;
    logic [15:0] stat_host_grants;
    logic [15:0] stat_cpu_stalls;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] sram [0:1023];

    dmem_port_arbiter dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .enable           (enable),
        .cpu_req          (cpu_req),
        .cpu_wen          (cpu_wen),
        .cpu_addr         (cpu_addr),
        .cpu_wdata        (cpu_wdata),
        .cpu_rdata        (cpu_rdata),
        .cpu_stall        (cpu_stall),
        .host_req         (host_req),
        .host_wen         (host_wen),
        .host_addr        (host_addr),
        .host_wdata       (host_wdata),
        .host_ack         (host_ack),
        .host_rdata       (host_rdata),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_wen          (mem_wen),
        .mem_ren          (mem_ren),
        .mem_rdata        (mem_rdata),
        .stat_host_grants (stat_host_grants),
        .stat_cpu_stalls  (stat_cpu_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple SRAM model: write on wen, registered read data one cycle later.
    always @(posedge clk) begin
        if (mem_wen) sram[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= sram[mem_addr];
    end

    typedef struct {
        logic        rst_n, en, creq, cwen;
        logic [9:0]  caddr;
        logic [31:0] cwdata;
        logic        hreq, hwen;
        logic [9:0]  haddr;
        logic [31:0] hwdata;
        logic        e_stall, e_ack, e_wen, e_ren;
        logic [9:0]  e_addr;
        logic [31:0] e_wdata, e_hrdata;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(
        input logic rst_n, input logic en, input logic creq, input logic cwen,
        input logic [9:0] caddr, input logic [31:0] cwdata,
        input logic hreq, input logic hwen, input logic [9:0] haddr, input logic [31:0] hwdata,
        input logic e_stall, input logic e_ack, input logic e_wen, input logic e_ren,
        input logic [9:0] e_addr, input logic [31:0] e_wdata, input logic [31:0] e_hrdata);
        vec_t v;
        v.rst_n = rst_n; v.en = en; v.creq = creq; v.cwen = cwen;
        v.caddr = caddr; v.cwdata = cwdata;
        v.hreq = hreq; v.hwen = hwen; v.haddr = haddr; v.hwdata = hwdata;
        v.e_stall = e_stall; v.e_ack = e_ack; v.e_wen = e_wen; v.e_ren = e_ren;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_hrdata = e_hrdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst_n, input logic en, input logic creq, input logic cwen,
                         input logic [9:0] caddr, input logic [31:0] cwdata,
                         input logic hreq, input logic hwen, input logic [9:0] haddr,
                         input logic [31:0] hwdata);
        @(negedge clk);
        arst_n = rst_n; enable = en; cpu_req = creq; cpu_wen = cwen;
        cpu_addr = caddr; cpu_wdata = cwdata;
        host_req = hreq; host_wen = hwen; host_addr = haddr; host_wdata = hwdata;
        #2;
    endtask

    logic [15:0] exp_grants;
    logic [15:0] exp_stalls;

    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = 32'h0000_0000;
        mem_rdata = 32'h0000_0000;
        arst_n = 1'b0; enable = 1'b0; cpu_req = 1'b0; cpu_wen = 1'b0;
        cpu_addr = 10'd0; cpu_wdata = 32'h0; host_req = 1'b0; host_wen = 1'b0;
        host_addr = 10'd0; host_wdata = 32'h0;

        //            rst en cr cw caddr cwdata         hr hw haddr hwdata       | st ak wen ren addr wdata         hrdata
        vecs[0]  = mk(0, 1, 1, 1, 10'd3, 32'h11,        1, 1, 10'd5, 32'h22,       0, 0, 0, 0, 10'd0, 32'h0,        32'h0);
        vecs[1]  = mk(0, 1, 1, 1, 10'd3, 32'h11,        1, 1, 10'd5, 32'h22,       0, 0, 0, 0, 10'd0, 32'h0,        32'h0);
        vecs[2]  = mk(1, 0, 0, 0, 10'd0, 32'h0,         0, 0, 10'd0, 32'h0,        0, 0, 0, 0, 10'd0, 32'h0,        32'h0);
        vecs[3]  = mk(1, 0, 1, 1, 10'd3, 32'h11,        1, 1, 10'd5, 32'hDEADBEEF, 0, 0, 1, 0, 10'd5, 32'hDEADBEEF, 32'h0);
        vecs[4]  = mk(1, 0, 1, 1, 10'd3, 32'h11,        1, 1, 10'd5, 32'hDEADBEEF, 0, 1, 0, 0, 10'd0, 32'h0,        32'h0);
        vecs[5]  = mk(1, 0, 0, 0, 10'd0, 32'h0,         1, 0, 10'd5, 32'h0,        0, 0, 0, 1, 10'd5, 32'h0,        32'h0);
        vecs[6]  = mk(1, 0, 0, 0, 10'd0, 32'h0,         1, 0, 10'd5, 32'h0,        0, 1, 0, 0, 10'd0, 32'h0,        32'hDEADBEEF);
        vecs[7]  = mk(1, 0, 0, 0, 10'd0, 32'h0,         0, 0, 10'd0, 32'h0,        0, 0, 0, 0, 10'd0, 32'h0,        32'h0);
        vecs[8]  = mk(1, 1, 1, 1, 10'd7, 32'hCAFEF00D,  0, 0, 10'd0, 32'h0,        0, 0, 1, 0, 10'd7, 32'hCAFEF00D, 32'h0);
        vecs[9]  = mk(1, 1, 0, 0, 10'd0, 32'h0,         1, 0, 10'd7, 32'h0,        0, 0, 0, 1, 10'd7, 32'h0,        32'h0);
        vecs[10] = mk(1, 1, 1, 0, 10'd5, 32'h0,         0, 0, 10'd0, 32'h0,        0, 1, 0, 1, 10'd5, 32'h0,        32'hCAFEF00D);
        vecs[11] = mk(1, 1, 0, 0, 10'd0, 32'h0,         0, 0, 10'd0, 32'h0,        0, 0, 0, 0, 10'd0, 32'h0,        32'h0);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].creq, vecs[i].cwen, vecs[i].caddr,
                  vecs[i].cwdata, vecs[i].hreq, vecs[i].hwen, vecs[i].haddr, vecs[i].hwdata);
            check($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].e_stall));
            check($sformatf("v%0d_ack", i), 32'(host_ack), 32'(vecs[i].e_ack));
            check($sformatf("v%0d_wen", i), 32'(mem_wen), 32'(vecs[i].e_wen));
            check($sformatf("v%0d_ren", i), 32'(mem_ren), 32'(vecs[i].e_ren));
            check($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
            check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].e_wdata);
            check($sformatf("v%0d_hrdata", i), host_rdata, vecs[i].e_hrdata);
        end

        // Reset arriving while a host response is pending: no ack ever appears.
        drive(1, 1, 0, 0, 10'd0, 32'h0, 1, 0, 10'd5, 32'h0);
        check("rr_grant_ren", 32'(mem_ren), 32'd1);
        drive(0, 1, 1, 0, 10'd5, 32'h0, 1, 0, 10'd5, 32'h0);
        check("rr_ack_in_reset", 32'(host_ack), 32'd0);
        check("rr_stall_in_reset", 32'(cpu_stall), 32'd0);
        check("rr_ren_in_reset", 32'(mem_ren), 32'd0);
        check("rr_hrdata_in_reset", host_rdata, 32'h0);
        drive(1, 0, 0, 0, 10'd0, 32'h0, 0, 0, 10'd0, 32'h0);
        check("rr_ack_after_reset", 32'(host_ack), 32'd0);
        check("rr_stat_grants0", 32'(stat_host_grants), 32'd0);
        check("rr_stat_stalls0", 32'(stat_cpu_stalls), 32'd0);

        // CPU reads continuously; host write starves and is forced at cycle 4.
        for (int c = 0; c < 7; c++) begin
            drive(1, 1, 1, 0, 10'd5, 32'h0, (c < 5), 1, 10'd9, 32'h12345678);
            check($sformatf("sv_c%0d_stall", c), 32'(cpu_stall), 32'(c == 4));
            check($sformatf("sv_c%0d_ack", c), 32'(host_ack), 32'(c == 5));
            check($sformatf("sv_c%0d_wen", c), 32'(mem_wen), 32'(c == 4));
            check($sformatf("sv_c%0d_ren", c), 32'(mem_ren), 32'(c != 4));
            check($sformatf("sv_c%0d_addr", c), 32'(mem_addr), (c == 4) ? 32'd9 : 32'd5);
            check($sformatf("sv_c%0d_hrdata", c), host_rdata, 32'h0);
            if (c >= 1) check($sformatf("sv_c%0d_cpu_rdata", c), cpu_rdata, 32'hDEADBEEF);
        end
        check("sv_sram_written", sram[9], 32'h12345678);

`ifdef DMEM_ARB_STATS_EN
        exp_grants = 16'd1;
        exp_stalls = 16'd1;
`else
        exp_grants = 16'd0;
        exp_stalls = 16'd0;
`endif
        check("stat_host_grants", 32'(stat_host_grants), 32'(exp_grants));
        check("stat_cpu_stalls", 32'(stat_cpu_stalls), 32'(exp_stalls));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
